// File: rtl/avalon_pio_pulse_out.sv
// avalon_pio_pulse_out
// Avalon-MM output port with atomic SET/CLEAR and a timed pulse engine.
// The pulse engine inverts a latched group of DATA bits for LEN cycles, then
// restores them.
// Optional feature macro: PULSE_IRQ_EN (pulse-done interrupt with CTRL ack).
//
// state | meaning
// IDLE  | no pulse in flight, waiting for START with LEN != 0
// PULSE | mask_lat bits inverted on out_port, cnt counting down to 1

module avalon_pio_pulse_out #(
  parameter int              WIDTH     = 8,
  parameter int              CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_SET   = 3'd1;
  localparam logic [2:0] ADDR_CLEAR = 3'd2;
  localparam logic [2:0] ADDR_MASK  = 3'd3;
  localparam logic [2:0] ADDR_LEN   = 3'd4;
  localparam logic [2:0] ADDR_CTRL  = 3'd5;

  typedef enum logic [0:0] {IDLE, PULSE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_lat;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic             irq_pending;

  logic wr;
  logic wr_ctrl;
  logic start;
  logic busy;
  logic [WIDTH-1:0] wd;

  // Upper writedata bits are only meaningful for some registers.
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr && (address == ADDR_CTRL);
  assign start   = wr_ctrl & writedata[0];
  assign busy    = (state == PULSE);
  assign wd      = writedata[WIDTH-1:0];

  // Bus-visible registers: DATA with atomic SET/CLEAR, MASK and LEN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
      mask_q <= '0;
      len_q  <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:  data_q <= wd;
        ADDR_SET:   data_q <= data_q | wd;
        ADDR_CLEAR: data_q <= data_q & ~wd;
        ADDR_MASK:  mask_q <= wd;
        ADDR_LEN:   len_q  <= writedata[CNT_W-1:0];
        default:    ;
      endcase
    end
  end

  // Pulse engine: mask and length are latched at START so later bus writes
  // to MASK/LEN cannot disturb a pulse in flight; START while busy is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mask_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (len_q != '0)) begin
            mask_lat <= mask_q;
            cnt      <= len_q;
            state    <= PULSE;
          end
        end
        PULSE: begin
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PULSE_IRQ_EN
  logic pulse_done;
  logic irq_ack;

  assign pulse_done = busy && (cnt == CNT_W'(1));
  assign irq_ack    = wr_ctrl & writedata[1];

  // Pending flag: a pulse ending on the same edge as an ack keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_pending <= 1'b0;
    end else if (pulse_done) begin
      irq_pending <= 1'b1;
    end else if (irq_ack) begin
      irq_pending <= 1'b0;
    end
  end
`else
  assign irq_pending = 1'b0;
`endif

  assign irq      = irq_pending;
  assign out_port = data_q ^ (busy ? mask_lat : '0);

  // Zero-latency read mux; write-only and unmapped addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(data_q);
      ADDR_MASK: readdata = 32'(mask_q);
      ADDR_LEN:  readdata = 32'(len_q);
      ADDR_CTRL: readdata = {30'd0, irq_pending, busy};
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_pulse_out.sv
// Directed testbench for avalon_pio_pulse_out (WIDTH=8, CNT_W=16, RESET_VAL=8'hA5).
// Builds with or without PULSE_IRQ_EN; irq expectations follow the macro.

module tb_avalon_pio_pulse_out;

`ifdef PULSE_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rd;

  avalon_pio_pulse_out #(
    .WIDTH(8),
    .CNT_W(16),
    .RESET_VAL(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus write; returns 1 time unit after the write edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (out_port !== 8'hA5) begin n_bad++; $display("FAIL reset_out: got %h want a5", out_port); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    bus_read(3'd0, rd);
    n_cmp++; if (rd !== 32'hA5) begin n_bad++; $display("FAIL reset_data_rd: got %h want 000000a5", rd); end
    bus_read(3'd5, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl_rd: got %h want 0", rd); end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_registers();
    bus_write(3'd0, 32'hFFFF_FF0F);
    bus_write(3'd1, 32'h30);
    bus_write(3'd2, 32'h03);
    n_cmp++; if (out_port !== 8'h3C) begin n_bad++; $display("FAIL set_clear_out: got %h want 3c", out_port); end
    bus_read(3'd0, rd);
    n_cmp++; if (rd !== 32'h3C) begin n_bad++; $display("FAIL data_rd: got %h want 0000003c", rd); end
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL set_rd: got %h want 0", rd); end
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL clear_rd: got %h want 0", rd); end
    bus_write(3'd7, 32'hFF);
    bus_write(3'd6, 32'hFF);
    bus_read(3'd6, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL undef_rd: got %h want 0", rd); end
    n_cmp++; if (out_port !== 8'h3C) begin n_bad++; $display("FAIL undef_wr_ignored: got %h want 3c", out_port); end
    bus_write(3'd4, 32'h0001_1234);
    bus_read(3'd4, rd);
    n_cmp++; if (rd !== 32'h1234) begin n_bad++; $display("FAIL len_rd: got %h want 00001234", rd); end
  endtask

  task automatic test_pulse();
    bus_write(3'd0, 32'h00);
    bus_write(3'd3, 32'h01);
    bus_write(3'd4, 32'd5);
    bus_write(3'd5, 32'h1);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_port !== 8'h01) begin n_bad++; $display("FAIL pulse_out[%0d]: got %h want 01", i, out_port); end
      bus_read(3'd5, rd);
      n_cmp++; if (rd[0] !== 1'b1) begin n_bad++; $display("FAIL pulse_busy[%0d]: got %b want 1", i, rd[0]); end
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL pulse_irq_low[%0d]: got %b want 0", i, irq); end
      step();
    end
    n_cmp++; if (out_port !== 8'h00) begin n_bad++; $display("FAIL pulse_end_out: got %h want 00", out_port); end
    bus_read(3'd5, rd);
    n_cmp++; if (rd !== {30'd0, IRQ_EXP, 1'b0}) begin n_bad++; $display("FAIL pulse_end_ctrl: got %h want %h", rd, {30'd0, IRQ_EXP, 1'b0}); end
    n_cmp++; if (irq !== IRQ_EXP) begin n_bad++; $display("FAIL pulse_end_irq: got %b want %b", irq, IRQ_EXP); end
  endtask

  task automatic test_no_retrigger();
    bus_write(3'd5, 32'h2);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL ack_irq: got %b want 0", irq); end
    bus_write(3'd5, 32'h1);
    bus_write(3'd5, 32'h1);
    bus_write(3'd4, 32'd100);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_port !== 8'h01) begin n_bad++; $display("FAIL retrig_out[%0d]: got %h want 01", i, out_port); end
      step();
    end
    n_cmp++; if (out_port !== 8'h00) begin n_bad++; $display("FAIL retrig_end_out: got %h want 00", out_port); end
    bus_read(3'd5, rd);
    n_cmp++; if (rd[0] !== 1'b0) begin n_bad++; $display("FAIL retrig_end_busy: got %b want 0", rd[0]); end
    n_cmp++; if (irq !== IRQ_EXP) begin n_bad++; $display("FAIL retrig_end_irq: got %b want %b", irq, IRQ_EXP); end
    bus_read(3'd4, rd);
    n_cmp++; if (rd !== 32'd100) begin n_bad++; $display("FAIL retrig_len_rd: got %h want 00000064", rd); end
  endtask

  task automatic test_len_zero();
    bus_write(3'd5, 32'h2);
    bus_write(3'd4, 32'd0);
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL len0_ctrl: got %h want 0", rd); end
    n_cmp++; if (out_port !== 8'h00) begin n_bad++; $display("FAIL len0_out: got %h want 00", out_port); end
    step();
    step();
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL len0_irq: got %b want 0", irq); end
    n_cmp++; if (out_port !== 8'h00) begin n_bad++; $display("FAIL len0_out_late: got %h want 00", out_port); end
  endtask

  task automatic test_data_while_busy();
    bus_write(3'd4, 32'd4);
    bus_write(3'd5, 32'h1);
    bus_write(3'd1, 32'hF0);
    n_cmp++; if (out_port !== 8'hF1) begin n_bad++; $display("FAIL busy_set_out: got %h want f1", out_port); end
    bus_read(3'd0, rd);
    n_cmp++; if (rd !== 32'hF0) begin n_bad++; $display("FAIL busy_set_data: got %h want 000000f0", rd); end
    step();
    step();
    n_cmp++; if (out_port !== 8'hF1) begin n_bad++; $display("FAIL busy_last_out: got %h want f1", out_port); end
    step();
    n_cmp++; if (out_port !== 8'hF0) begin n_bad++; $display("FAIL busy_end_out: got %h want f0", out_port); end
  endtask

  task automatic test_irq_ack();
    bus_write(3'd5, 32'h2);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL ack_drop: got %b want 0", irq); end
    bus_write(3'd4, 32'd3);
    bus_write(3'd5, 32'h1);
    bus_write(3'd5, 32'h0);
    bus_write(3'd5, 32'h0);
    bus_write(3'd5, 32'h2);
    n_cmp++; if (irq !== IRQ_EXP) begin n_bad++; $display("FAIL ack_vs_done_irq: got %b want %b", irq, IRQ_EXP); end
    bus_read(3'd5, rd);
    n_cmp++; if (rd !== {30'd0, IRQ_EXP, 1'b0}) begin n_bad++; $display("FAIL ack_vs_done_ctrl: got %h want %h", rd, {30'd0, IRQ_EXP, 1'b0}); end
    bus_write(3'd5, 32'h3);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL start_ack_irq: got %b want 0", irq); end
    bus_read(3'd5, rd);
    n_cmp++; if (rd[0] !== 1'b1) begin n_bad++; $display("FAIL start_ack_busy: got %b want 1", rd[0]); end
    step();
    step();
    step();
    n_cmp++; if (irq !== IRQ_EXP) begin n_bad++; $display("FAIL start_ack_end_irq: got %b want %b", irq, IRQ_EXP); end
    n_cmp++; if (out_port !== 8'hF0) begin n_bad++; $display("FAIL start_ack_end_out: got %h want f0", out_port); end
  endtask

  task automatic test_reset_mid_pulse();
    bus_write(3'd0, 32'h00);
    bus_write(3'd4, 32'd10);
    bus_write(3'd5, 32'h1);
    step();
    n_cmp++; if (out_port !== 8'h01) begin n_bad++; $display("FAIL rst_pre_out: got %h want 01", out_port); end
    reset = 1'b1;
    #1;
    n_cmp++; if (out_port !== 8'hA5) begin n_bad++; $display("FAIL rst_async_out: got %h want a5", out_port); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_async_irq: got %b want 0", irq); end
    @(negedge clk);
    reset = 1'b0;
    step();
    bus_read(3'd5, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_ctrl: got %h want 0", rd); end
    bus_read(3'd3, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_mask: got %h want 0", rd); end
    bus_read(3'd4, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_len: got %h want 0", rd); end
    for (int i = 0; i < 12; i++) step();
    n_cmp++; if (out_port !== 8'hA5) begin n_bad++; $display("FAIL rst_hold_out: got %h want a5", out_port); end
  endtask

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;
    test_reset();
    test_registers();
    test_pulse();
    test_no_retrigger();
    test_len_zero();
    test_data_while_busy();
    test_irq_ack();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
